// File: rtl/dpll_acq_sequencer.sv
// DPLL acquisition/relock sequencer: coarse -> fine -> locked tracking with
// debounced lock qualification, bounded retries and a sticky fault state.
module dpll_acq_sequencer #(
  parameter int COARSE_CYC   = 64,
  parameter int FINE_TIMEOUT = 256,
  parameter int LOCK_QUAL    = 16,
  parameter int UNLOCK_QUAL  = 4,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk_ref,
  input  logic       rst,
  input  logic       enable,
  input  logic       lock_raw,
  output logic [1:0] gain_sel,
  output logic       dco_freeze,
  output logic       lock,
  output logic       relock_evt,
  output logic       acq_fail,
  output logic [2:0] state,
  output logic [3:0] retry_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_COARSE = 3'd1;
  localparam logic [2:0] S_FINE   = 3'd2;
  localparam logic [2:0] S_LOCKED = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam int M1   = (COARSE_CYC > FINE_TIMEOUT) ? COARSE_CYC : FINE_TIMEOUT;
  localparam int M2   = (LOCK_QUAL > UNLOCK_QUAL) ? LOCK_QUAL : UNLOCK_QUAL;
  localparam int MAXP = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXP) + 1;

  // Terminal values are compared against the pre-increment count, so the
  // transition lands on exactly the N-th counted cycle.
  localparam logic [CW-1:0] COARSE_LAST = CW'(COARSE_CYC - 1);
  localparam logic [CW-1:0] FINE_LAST   = CW'(FINE_TIMEOUT - 1);
  localparam logic [CW-1:0] LQ_LAST     = CW'(LOCK_QUAL - 1);
  localparam logic [CW-1:0] UQ_LAST     = CW'(UNLOCK_QUAL - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] lq_q, lq_d;
  logic [CW-1:0] uq_q, uq_d;
  logic [3:0]    retry_q, retry_d;
  logic          relock_d;
  logic [1:0]    gain_q;
  logic          freeze_q, lock_q, relock_q, fail_q;
  logic [4:0]    outs_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Output word {gain_sel, dco_freeze, lock, acq_fail} for a given state.
  function automatic logic [4:0] out_dec(input logic [2:0] s);
    case (s)
      S_COARSE: return {2'd3, 1'b0, 1'b0, 1'b0};
      S_FINE:   return {2'd2, 1'b0, 1'b0, 1'b0};
      S_LOCKED: return {2'd1, 1'b0, 1'b1, 1'b0};
      S_FAULT:  return {2'd0, 1'b1, 1'b0, 1'b1};
      default:  return {2'd0, 1'b1, 1'b0, 1'b0};
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    lq_d     = lq_q;
    uq_d     = uq_q;
    retry_d  = retry_q;
    relock_d = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      cyc_d   = '0;
      lq_d    = '0;
      uq_d    = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_COARSE;
          cyc_d   = '0;
          lq_d    = '0;
          uq_d    = '0;
          retry_d = '0;
        end
        S_COARSE: begin
          if (cyc_q == COARSE_LAST) begin
            state_d = S_FINE;
            cyc_d   = '0;
            lq_d    = '0;
            uq_d    = '0;
          end else begin
            cyc_d = sat_inc(cyc_q);
          end
        end
        S_FINE: begin
          cyc_d = sat_inc(cyc_q);
          lq_d  = lock_raw ? sat_inc(lq_q) : '0;
          // Lock qualification takes precedence over a coincident timeout.
          if (lock_raw && (lq_q == LQ_LAST)) begin
            state_d = S_LOCKED;
            cyc_d   = '0;
            lq_d    = '0;
            uq_d    = '0;
            retry_d = '0;
          end else if (cyc_q == FINE_LAST) begin
            cyc_d = '0;
            lq_d  = '0;
            uq_d  = '0;
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 4'd1;
              state_d = S_COARSE;
            end else begin
              state_d = S_FAULT;
            end
          end
        end
        S_LOCKED: begin
          uq_d = lock_raw ? '0 : sat_inc(uq_q);
          if (!lock_raw && (uq_q == UQ_LAST)) begin
            state_d  = S_FINE;
            relock_d = 1'b1;
            cyc_d    = '0;
            lq_d     = '0;
            uq_d     = '0;
          end
        end
        S_FAULT: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign outs_d = out_dec(state_d);

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      lq_q     <= '0;
      uq_q     <= '0;
      retry_q  <= '0;
      gain_q   <= 2'd0;
      freeze_q <= 1'b1;
      lock_q   <= 1'b0;
      relock_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      lq_q     <= lq_d;
      uq_q     <= uq_d;
      retry_q  <= retry_d;
      gain_q   <= outs_d[4:3];
      freeze_q <= outs_d[2];
      lock_q   <= outs_d[1];
      fail_q   <= outs_d[0];
      relock_q <= relock_d;
    end
  end

  assign gain_sel   = gain_q;
  assign dco_freeze = freeze_q;
  assign lock       = lock_q;
  assign relock_evt = relock_q;
  assign acq_fail   = fail_q;
  assign state      = state_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_dpll_acq_sequencer.sv
// Scoreboard bench for dpll_acq_sequencer: one default instance and one with
// short coarse/fine windows (LOCK_QUAL == FINE_TIMEOUT == 16).
module tb_dpll_acq_sequencer;

  logic clk = 1'b0;
  logic rst, enable, lock_raw;
  always #5 clk = ~clk;

  logic [1:0] gs0, gs1;
  logic       fz0, fz1, lk0, lk1, rl0, rl1, af0, af1;
  logic [2:0] st0, st1;
  logic [3:0] rc0, rc1;

  dpll_acq_sequencer u0 (
    .clk_ref(clk), .rst(rst), .enable(enable), .lock_raw(lock_raw),
    .gain_sel(gs0), .dco_freeze(fz0), .lock(lk0), .relock_evt(rl0),
    .acq_fail(af0), .state(st0), .retry_cnt(rc0)
  );

  dpll_acq_sequencer #(.COARSE_CYC(8), .FINE_TIMEOUT(16)) u1 (
    .clk_ref(clk), .rst(rst), .enable(enable), .lock_raw(lock_raw),
    .gain_sel(gs1), .dco_freeze(fz1), .lock(lk1), .relock_evt(rl1),
    .acq_fail(af1), .state(st1), .retry_cnt(rc1)
  );

  localparam logic [2:0] IDLE = 3'd0, COARSE = 3'd1, FINE = 3'd2,
                         LOCKED = 3'd3, FAULT = 3'd4;

  typedef struct {
    int          dut;
    string       name;
    logic [12:0] vec;
    bit          chk_rc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   kcur = 0;

  // Expected vector layout: {state, gain_sel, dco_freeze, lock, relock_evt, acq_fail, retry_cnt}
  task automatic push(input int d, input string nm, input logic [2:0] s,
                      input logic rl, input logic [3:0] rc, input bit crc);
    exp_t e;
    logic [1:0] g;
    logic f, l, a;
    case (s)
      COARSE:  begin g = 2'd3; f = 1'b0; l = 1'b0; a = 1'b0; end
      FINE:    begin g = 2'd2; f = 1'b0; l = 1'b0; a = 1'b0; end
      LOCKED:  begin g = 2'd1; f = 1'b0; l = 1'b1; a = 1'b0; end
      FAULT:   begin g = 2'd0; f = 1'b1; l = 1'b0; a = 1'b1; end
      default: begin g = 2'd0; f = 1'b1; l = 1'b0; a = 1'b0; end
    endcase
    e.dut = d; e.name = nm; e.vec = {s, g, f, l, rl, a, rc}; e.chk_rc = crc;
    sbq.push_back(e);
  endtask

  task automatic push2(input string nm, input logic [2:0] s, input logic [3:0] rc);
    push(0, nm, s, 1'b0, rc, 1'b1);
    push(1, nm, s, 1'b0, rc, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    kcur++;
  endtask

  task automatic run_to(input int t);
    while (kcur < t) tick();
  endtask

  // Monitor: compares every pending expectation against the DUT outputs on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic [12:0] act, msk;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = (e.dut == 0) ? {st0, gs0, fz0, lk0, rl0, af0, rc0}
                         : {st1, gs1, fz1, lk1, rl1, af1, rc1};
      msk = e.chk_rc ? 13'h1FFF : 13'h1FF0;
      checks++;
      if ((act & msk) !== (e.vec & msk)) begin
        failures++;
        $display("FAIL %s dut%0d {st,gs,frz,lk,rl,af,rc} actual=%b required=%b",
                 e.name, e.dut, act, e.vec);
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; lock_raw = 1'b1;
    #1;
    push2("reset", IDLE, 4'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    push2("idle_disabled", IDLE, 4'd0);

    // Nominal acquisition with lock_raw held high; u1 also exercises lock-vs-timeout.
    enable = 1'b1;
    kcur = -1;
    tick();
    push2("enter_coarse", COARSE, 4'd0);
    run_to(7);  push(1, "u1_coarse_end", COARSE, 1'b0, 4'd0, 1'b1);
    run_to(8);  push(1, "u1_fine", FINE, 1'b0, 4'd0, 1'b1);
    run_to(23); push(1, "u1_fine_end", FINE, 1'b0, 4'd0, 1'b1);
    run_to(24); push(1, "simul_lock_wins", LOCKED, 1'b0, 4'd0, 1'b1);
    run_to(63); push(0, "coarse_end", COARSE, 1'b0, 4'd0, 1'b1);
    run_to(64); push(0, "fine_entry", FINE, 1'b0, 4'd0, 1'b1);
    run_to(79); push(0, "fine_qual", FINE, 1'b0, 4'd0, 1'b1);
    run_to(80); push(0, "nominal_lock", LOCKED, 1'b0, 4'd0, 1'b1);

    // Loss of lock: 0,0,0,1 holds lock; four zeros drop to FINE with a relock pulse.
    lock_raw = 1'b0;
    run_to(83); push(0, "unlock_3zeros", LOCKED, 1'b0, 4'd0, 1'b1);
    lock_raw = 1'b1;
    run_to(84); push(0, "unlock_glitch", LOCKED, 1'b0, 4'd0, 1'b1);
    lock_raw = 1'b0;
    run_to(87); push(0, "unlock_pre", LOCKED, 1'b0, 4'd0, 1'b1);
    run_to(88); push(0, "relock_pulse", FINE, 1'b1, 4'd0, 1'b1);
    lock_raw = 1'b1;

    // Debounce from FINE entry at k=88: 15 ones, 1 zero, 16 ones.
    for (int k = 89; k <= 119; k++) begin
      run_to(k);
      push(0, "debounce_nolock", FINE, 1'b0, 4'd0, 1'b1);
      lock_raw = (k == 103) ? 1'b0 : 1'b1;
    end
    run_to(120); push(0, "debounce_lock", LOCKED, 1'b0, 4'd0, 1'b1);

    // Async reset mid-LOCKED, between clock edges.
    run_to(122);
    #2 rst = 1'b1;
    push2("async_rst_locked", IDLE, 4'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    push2("restart_locked", COARSE, 4'd0);
    kcur = 0;
    lock_raw = 1'b0;

    // Async reset mid-FINE.
    run_to(64); push(0, "fine_before_rst", FINE, 1'b0, 4'd0, 1'b1);
    run_to(69);
    #2 rst = 1'b1;
    push2("async_rst_fine", IDLE, 4'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    push2("restart_fine", COARSE, 4'd0);
    kcur = 0;

    // Retry to fault with lock_raw held low.
    run_to(24);   push(1, "u1_retry1", COARSE, 1'b0, 4'd1, 1'b1);
    run_to(48);   push(1, "u1_retry2", COARSE, 1'b0, 4'd2, 1'b1);
    run_to(72);   push(1, "u1_retry3", COARSE, 1'b0, 4'd3, 1'b1);
    run_to(95);   push(1, "u1_last_fine", FINE, 1'b0, 4'd3, 1'b1);
    run_to(96);   push(1, "u1_fault", FAULT, 1'b0, 4'd3, 1'b1);
    run_to(319);  push(0, "timeout_pre", FINE, 1'b0, 4'd0, 1'b1);
    run_to(320);  push(0, "retry1", COARSE, 1'b0, 4'd1, 1'b1);
    run_to(640);  push(0, "retry2", COARSE, 1'b0, 4'd2, 1'b1);
    run_to(960);  push(0, "retry3", COARSE, 1'b0, 4'd3, 1'b1);
    run_to(1279); push(0, "last_fine", FINE, 1'b0, 4'd3, 1'b1);
    run_to(1280); push(0, "fault", FAULT, 1'b0, 4'd3, 1'b1);
    run_to(1290); push2("fault_sticky", FAULT, 4'd3);

    enable = 1'b0;
    tick();
    push(0, "fault_exit", IDLE, 1'b0, 4'd0, 1'b0);
    push(1, "fault_exit", IDLE, 1'b0, 4'd0, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
